// File: rtl/chaining_record_writer_pkg.sv
// -----------------------------------------------------------------------------
// chaining_record_writer_pkg
//
// Types and constants shared between the chaining record writer and the
// per-read chaining-check comparators.
//   - chaining_record_t : the record that is exported to the comparators.
//                         A set elementMask bit means "element written".
//   - slot_state_e      : per-slot lifecycle (IDLE / ACTIVE / DONE).
//   - REGS_PER_GROUP, ELEMS_PER_REG : geometry of the element mask.
//   - mask_bit_index()  : maps (register offset, element offset) to a mask bit.
// -----------------------------------------------------------------------------
package chaining_record_writer_pkg;

    localparam int REGS_PER_GROUP = 8;
    localparam int ELEMS_PER_REG  = 64;
    localparam int ELEMENT_MASK_W = REGS_PER_GROUP * ELEMS_PER_REG;
    localparam int COUNT_W        = 10;

    typedef struct packed {
        logic                      vd_valid;
        logic [4:0]                vd;
        logic [2:0]                instIndex;
        logic [ELEMENT_MASK_W-1:0] elementMask;
    } chaining_record_t;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_ACTIVE = 2'd1,
        SLOT_DONE   = 2'd2
    } slot_state_e;

    // Register offset selects a 64-bit lane of the mask, element offset the
    // bit inside that lane.
    function automatic logic [8:0] mask_bit_index(input logic [2:0] rel_reg,
                                                  input logic [5:0] offset);
        return {rel_reg, offset};
    endfunction

endpackage

// File: rtl/chaining_record_slot.sv
// -----------------------------------------------------------------------------
// chaining_record_slot
//
// One chaining record: lifecycle FSM, element mask, written-element counter
// and the match logic for writes and retires.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   alloc_fire              : allocate this slot (only asserted while idle)
//   alloc_vd_valid/vd/instIndex/elemCount : new record contents
//   write_valid/instIndex/vd/offset       : writeback element report
//   retire_valid/instIndex  : instruction retirement
//   rec                     : current record (vd_valid, vd, instIndex, mask)
//   live                    : slot is ACTIVE or DONE
//   done                    : slot is DONE
//   write_hit               : this write belongs to this slot
//   write_oor               : write register lies outside the 8-register group
// -----------------------------------------------------------------------------
module chaining_record_slot
    import chaining_record_writer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alloc_fire,
    input  logic                   alloc_vd_valid,
    input  logic [4:0]             alloc_vd,
    input  logic [2:0]             alloc_instIndex,
    input  logic [COUNT_W-1:0]     alloc_elemCount,
    input  logic                   write_valid,
    input  logic [2:0]             write_instIndex,
    input  logic [4:0]             write_vd,
    input  logic [5:0]             write_offset,
    input  logic                   retire_valid,
    input  logic [2:0]             retire_instIndex,
    output chaining_record_t       rec,
    output logic                   live,
    output logic                   done,
    output logic                   write_hit,
    output logic                   write_oor
);

    slot_state_e          state;
    chaining_record_t     rec_q;
    logic [COUNT_W-1:0]   count;
    logic [COUNT_W-1:0]   elem_count;
    logic [COUNT_W-1:0]   count_next;
    logic [4:0]           rel;
    logic [8:0]           bit_idx;
    logic                 retire_hit;
    logic                 do_write;
    logic                 bit_was_set;

    assign live = (state != SLOT_IDLE);
    assign done = (state == SLOT_DONE);
    assign rec  = rec_q;

    assign write_hit  = write_valid & live & rec_q.vd_valid &
                        (rec_q.instIndex == write_instIndex);
    // Register distance wraps modulo 32, so a write below the base register
    // lands far out of range rather than negative.
    assign rel        = write_vd - rec_q.vd;
    assign write_oor  = (rel[4:3] != 2'b00);
    assign bit_idx    = mask_bit_index(rel[2:0], write_offset);
    assign retire_hit = retire_valid & live & (rec_q.instIndex == retire_instIndex);

    // Retire wins over a write landing on the same slot in the same cycle.
    assign do_write    = write_hit & ~write_oor & ~retire_hit;
    assign bit_was_set = rec_q.elementMask[bit_idx];
    assign count_next  = count + COUNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset || retire_hit) begin
            state      <= SLOT_IDLE;
            rec_q      <= '0;
            count      <= '0;
            elem_count <= '0;
        end else if (alloc_fire) begin
            state                <= SLOT_ACTIVE;
            rec_q.vd_valid       <= alloc_vd_valid;
            rec_q.vd             <= alloc_vd;
            rec_q.instIndex      <= alloc_instIndex;
            rec_q.elementMask    <= '0;
            count                <= '0;
            elem_count           <= alloc_elemCount;
        end else if (do_write) begin
            rec_q.elementMask[bit_idx] <= 1'b1;
            // Only first-time writes count, so the counter tracks the number
            // of distinct elements and can never wrap.
            if ((state == SLOT_ACTIVE) && !bit_was_set) begin
                count <= count_next;
                if (count_next == elem_count) begin
                    state <= SLOT_DONE;
                end
            end
        end
    end

endmodule

// File: rtl/chaining_record_writer.sv
// -----------------------------------------------------------------------------
// chaining_record_writer
//
// Write side of the vector chaining scoreboard. Allocates a record per issued
// instruction, sets element-mask bits as writeback elements land and frees
// the record on retire. Records are exported flat for the chaining checks.
//
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   alloc_valid / alloc_ready         : allocation handshake
//   alloc_vd_valid, alloc_vd, alloc_instIndex, alloc_elemCount : new record
//   write_valid, write_instIndex, write_vd, write_offset        : element write
//   retire_valid, retire_instIndex    : instruction retirement
//   rec_valid, rec_vd_valid, rec_vd, rec_instIndex, rec_elementMask, rec_done
//                                     : flattened per-slot record state
//   write_err                         : registered pulse for an unmatched or
//                                       out-of-range write
// -----------------------------------------------------------------------------
module chaining_record_writer
    import chaining_record_writer_pkg::*;
#(
    parameter int NUM_RECORDS = 4,
    parameter int MASK_W      = 512
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic                          alloc_vd_valid,
    input  logic [4:0]                    alloc_vd,
    input  logic [2:0]                    alloc_instIndex,
    input  logic [9:0]                    alloc_elemCount,
    input  logic                          write_valid,
    input  logic [2:0]                    write_instIndex,
    input  logic [4:0]                    write_vd,
    input  logic [5:0]                    write_offset,
    input  logic                          retire_valid,
    input  logic [2:0]                    retire_instIndex,
    output logic [NUM_RECORDS-1:0]        rec_valid,
    output logic [NUM_RECORDS-1:0]        rec_vd_valid,
    output logic [5*NUM_RECORDS-1:0]      rec_vd,
    output logic [3*NUM_RECORDS-1:0]      rec_instIndex,
    output logic [MASK_W*NUM_RECORDS-1:0] rec_elementMask,
    output logic [NUM_RECORDS-1:0]        rec_done,
    output logic                          write_err
);

    chaining_record_t          recs [NUM_RECORDS];
    logic [NUM_RECORDS-1:0]    live;
    logic [NUM_RECORDS-1:0]    done;
    logic [NUM_RECORDS-1:0]    write_hit;
    logic [NUM_RECORDS-1:0]    write_oor;
    logic [NUM_RECORDS-1:0]    dup_hit;
    logic [NUM_RECORDS-1:0]    first_idle;
    logic                      found_idle;
    logic                      alloc_fire;
    logic                      err_next;

    // Lowest-numbered idle slot, from pre-retire state so a slot retiring
    // this cycle is not reused until the next one.
    always_comb begin
        first_idle = '0;
        found_idle = 1'b0;
        for (int i = 0; i < NUM_RECORDS; i++) begin
            if (!live[i] && !found_idle) begin
                first_idle[i] = 1'b1;
                found_idle    = 1'b1;
            end
        end
    end

    assign alloc_ready = found_idle & ~(|dup_hit);
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Live instIndex values are unique, so at most one slot can hit.
    assign err_next = write_valid & (~(|write_hit) | (|(write_hit & write_oor)));

    for (genvar i = 0; i < NUM_RECORDS; i++) begin : g_slot
        chaining_record_slot u_slot (
            .clock            (clock),
            .reset            (reset),
            .alloc_fire       (alloc_fire & first_idle[i]),
            .alloc_vd_valid   (alloc_vd_valid),
            .alloc_vd         (alloc_vd),
            .alloc_instIndex  (alloc_instIndex),
            .alloc_elemCount  (alloc_elemCount),
            .write_valid      (write_valid),
            .write_instIndex  (write_instIndex),
            .write_vd         (write_vd),
            .write_offset     (write_offset),
            .retire_valid     (retire_valid),
            .retire_instIndex (retire_instIndex),
            .rec              (recs[i]),
            .live             (live[i]),
            .done             (done[i]),
            .write_hit        (write_hit[i]),
            .write_oor        (write_oor[i])
        );

        assign dup_hit[i] = live[i] & (recs[i].instIndex == alloc_instIndex);

        assign rec_valid[i]                        = live[i];
        assign rec_done[i]                         = done[i];
        assign rec_vd_valid[i]                     = recs[i].vd_valid;
        assign rec_vd[5*i +: 5]                    = recs[i].vd;
        assign rec_instIndex[3*i +: 3]             = recs[i].instIndex;
        assign rec_elementMask[MASK_W*i +: MASK_W] = recs[i].elementMask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_err <= 1'b0;
        end else begin
            write_err <= err_next;
        end
    end

endmodule

// File: tb/tb_chaining_record_writer.sv
module tb_chaining_record_writer;

    localparam int N  = 4;
    localparam int MW = 512;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset = 1'b1;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic              alloc_vd_valid = 1'b0;
    logic [4:0]        alloc_vd = '0;
    logic [2:0]        alloc_instIndex = '0;
    logic [9:0]        alloc_elemCount = '0;
    logic              write_valid = 1'b0;
    logic [2:0]        write_instIndex = '0;
    logic [4:0]        write_vd = '0;
    logic [5:0]        write_offset = '0;
    logic              retire_valid = 1'b0;
    logic [2:0]        retire_instIndex = '0;
    logic [N-1:0]      rec_valid;
    logic [N-1:0]      rec_vd_valid;
    logic [5*N-1:0]    rec_vd;
    logic [3*N-1:0]    rec_instIndex;
    logic [MW*N-1:0]   rec_elementMask;
    logic [N-1:0]      rec_done;
    logic              write_err;

    chaining_record_writer #(.NUM_RECORDS(N), .MASK_W(MW)) dut (
        .clock            (clock),
        .reset            (reset),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_vd_valid   (alloc_vd_valid),
        .alloc_vd         (alloc_vd),
        .alloc_instIndex  (alloc_instIndex),
        .alloc_elemCount  (alloc_elemCount),
        .write_valid      (write_valid),
        .write_instIndex  (write_instIndex),
        .write_vd         (write_vd),
        .write_offset     (write_offset),
        .retire_valid     (retire_valid),
        .retire_instIndex (retire_instIndex),
        .rec_valid        (rec_valid),
        .rec_vd_valid     (rec_vd_valid),
        .rec_vd           (rec_vd),
        .rec_instIndex    (rec_instIndex),
        .rec_elementMask  (rec_elementMask),
        .rec_done         (rec_done),
        .write_err        (write_err)
    );

    typedef struct packed {
        logic [N-1:0]    valid;
        logic [N-1:0]    vd_valid;
        logic [N-1:0]    done;
        logic [5*N-1:0]  vd;
        logic [3*N-1:0]  inst;
        logic [MW*N-1:0] mask;
        logic            err;
    } snap_t;

    snap_t state_q[$];
    logic  ready_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    model_known = 1'b0;

    // Reference model: one entry per slot, done = distinct elements >= count.
    bit          m_live [N];
    bit          m_done [N];
    bit          m_vdv  [N];
    int          m_vd   [N];
    int          m_inst [N];
    int          m_cnt  [N];
    logic [MW-1:0] m_mask [N];
    bit          m_err;

    initial begin
        for (int s = 0; s < N; s++) begin
            m_live[s] = 0; m_done[s] = 0; m_vdv[s] = 0;
            m_vd[s] = 0; m_inst[s] = 0; m_cnt[s] = 0; m_mask[s] = '0;
        end
        m_err = 0;
    end

    function automatic bit model_ready(input int inst);
        bit idle = 0;
        bit dup  = 0;
        for (int s = 0; s < N; s++) begin
            if (!m_live[s]) idle = 1;
            else if (m_inst[s] == inst) dup = 1;
        end
        return idle && !dup;
    endfunction

    task automatic clear_slot(input int s);
        m_live[s] = 0; m_done[s] = 0; m_vdv[s] = 0;
        m_vd[s] = 0; m_inst[s] = 0; m_cnt[s] = 0; m_mask[s] = '0;
    endtask

    task automatic model_step();
        int pick = -1;
        int hit  = -1;
        int rel;
        bit rdy;
        if (reset) begin
            for (int s = 0; s < N; s++) clear_slot(s);
            m_err = 0;
            return;
        end
        rdy = model_ready(int'(alloc_instIndex));
        for (int s = N - 1; s >= 0; s--) if (!m_live[s]) pick = s;
        m_err = 0;
        if (write_valid) begin
            for (int s = 0; s < N; s++)
                if (m_live[s] && m_vdv[s] && m_inst[s] == int'(write_instIndex)) hit = s;
            if (hit < 0) m_err = 1;
            else begin
                rel = (int'(write_vd) - m_vd[hit] + 32) % 32;
                if (rel > 7) m_err = 1;
                else begin
                    m_mask[hit][rel * 64 + int'(write_offset)] = 1'b1;
                    if ($countones(m_mask[hit]) >= m_cnt[hit]) m_done[hit] = 1;
                end
            end
        end
        if (retire_valid)
            for (int s = 0; s < N; s++)
                if (m_live[s] && m_inst[s] == int'(retire_instIndex)) clear_slot(s);
        if (alloc_valid && rdy) begin
            m_live[pick] = 1; m_done[pick] = 0; m_vdv[pick] = alloc_vd_valid;
            m_vd[pick] = int'(alloc_vd); m_inst[pick] = int'(alloc_instIndex);
            m_cnt[pick] = int'(alloc_elemCount); m_mask[pick] = '0;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t e = '0;
        for (int s = 0; s < N; s++) begin
            e.valid[s]        = m_live[s];
            e.vd_valid[s]     = m_vdv[s];
            e.done[s]         = m_done[s];
            e.vd[s*5 +: 5]    = 5'(m_vd[s]);
            e.inst[s*3 +: 3]  = 3'(m_inst[s]);
            e.mask[s*MW +: MW] = m_mask[s];
        end
        e.err = m_err;
        return e;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_mask(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        int first = -1;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            for (int b = MW - 1; b >= 0; b--) if (got[b] !== exp[b]) first = b;
            $display("FAIL %s: got %0d bits set, expected %0d bits set, first differing bit %0d at %0t",
                     name, $countones(got), $countones(exp), first, $time);
        end
    endtask

    // One clock cycle: expectations are queued, the monitor compares them.
    task automatic step();
        if (model_known) ready_q.push_back(model_ready(int'(alloc_instIndex)));
        @(posedge clock);
        model_step();
        model_known = 1'b1;
        state_q.push_back(model_snap());
        #1;
        reset = 1'b0; alloc_valid = 1'b0; write_valid = 1'b0; retire_valid = 1'b0;
    endtask

    // Monitor
    initial begin
        snap_t e;
        logic  r;
        forever begin
            @(negedge clock);
            if (ready_q.size() > 0) begin
                r = ready_q.pop_front();
                check_val("alloc_ready", 32'(alloc_ready), 32'(r));
            end
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                check_val("rec_valid", 32'(rec_valid), 32'(e.valid));
                check_val("rec_vd_valid", 32'(rec_vd_valid), 32'(e.vd_valid));
                check_val("rec_done", 32'(rec_done), 32'(e.done));
                check_val("rec_vd", 32'(rec_vd), 32'(e.vd));
                check_val("rec_instIndex", 32'(rec_instIndex), 32'(e.inst));
                check_val("write_err", 32'(write_err), 32'(e.err));
                for (int s = 0; s < N; s++)
                    check_mask($sformatf("rec_elementMask[%0d]", s),
                               rec_elementMask[s*MW +: MW], e.mask[s*MW +: MW]);
            end
        end
    end

    task automatic set_alloc(input int vd, input int inst, input int cnt);
        alloc_valid = 1'b1; alloc_vd_valid = 1'b1;
        alloc_vd = 5'(vd); alloc_instIndex = 3'(inst); alloc_elemCount = 10'(cnt);
    endtask

    task automatic set_write(input int inst, input int vd, input int off);
        write_valid = 1'b1; write_instIndex = 3'(inst);
        write_vd = 5'(vd); write_offset = 6'(off);
    endtask

    task automatic set_retire(input int inst);
        retire_valid = 1'b1; retire_instIndex = 3'(inst);
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int live_q[$];
            int s;
            live_q.delete();
            for (int k = 0; k < N; k++) if (m_live[k]) live_q.push_back(k);
            reset           = ($urandom_range(0, 99) == 0);
            alloc_valid     = ($urandom_range(0, 2) == 0);
            alloc_vd_valid  = ($urandom_range(0, 9) != 0);
            alloc_vd        = 5'($urandom);
            alloc_instIndex = 3'($urandom);
            alloc_elemCount = 10'($urandom_range(1, 6));
            write_valid     = ($urandom_range(0, 9) < 7);
            if (live_q.size() > 0 && $urandom_range(0, 9) < 8) begin
                s = live_q[$urandom_range(0, live_q.size() - 1)];
                write_instIndex = 3'(m_inst[s]);
                if ($urandom_range(0, 9) == 0)
                    write_vd = 5'(m_vd[s] + int'($urandom_range(8, 31)));
                else
                    write_vd = 5'(m_vd[s] + int'($urandom_range(0, 1)));
            end else begin
                write_instIndex = 3'($urandom);
                write_vd        = 5'($urandom);
            end
            write_offset = 6'($urandom_range(0, 3));
            retire_valid = ($urandom_range(0, 9) == 0);
            if (live_q.size() > 0) retire_instIndex = 3'(m_inst[live_q[$urandom_range(0, live_q.size() - 1)]]);
            else retire_instIndex = 3'($urandom);
            step();
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1; step();
        reset = 1'b1; step();

        // First allocation and its writes
        set_alloc(8, 2, 3);
        #2 check_val("directed ready first alloc", 32'(alloc_ready), 32'd1);
        step();
        check_val("directed rec_valid[0]", 32'(rec_valid[0]), 32'd1);
        check_mask("directed fresh mask", rec_elementMask[MW-1:0], '0);
        set_write(2, 8, 5);  step();
        set_write(2, 9, 0);  step();
        set_write(2, 8, 5);  step();
        check_val("directed done before third element", 32'(rec_done[0]), 32'd0);
        set_write(2, 10, 63); step();
        check_val("directed done after third element", 32'(rec_done[0]), 32'd1);
        check_val("directed no write_err", 32'(write_err), 32'd0);
        check_val("directed mask bits 5/64/191",
                  {29'd0, rec_elementMask[191], rec_elementMask[64], rec_elementMask[5]}, 32'd7);
        check_val("directed mask popcount", 32'($countones(rec_elementMask[MW-1:0])), 32'd3);

        // Fill all slots, then retire while an alloc is held
        set_retire(2); step();
        for (int i = 0; i < 4; i++) begin
            set_alloc(8, i, 2); step();
        end
        set_alloc(8, 5, 2); set_retire(1);
        #2 check_val("directed ready when full", 32'(alloc_ready), 32'd0);
        step();
        check_val("directed slot1 retired", 32'(rec_valid[1]), 32'd0);
        set_alloc(8, 5, 2);
        #2 check_val("directed ready after retire", 32'(alloc_ready), 32'd1);
        step();
        check_val("directed slot1 reused", 32'(rec_instIndex[5:3]), 32'd5);

        // Duplicate alloc, unmatched write, out-of-range write
        set_alloc(8, 3, 2);
        #2 check_val("directed ready dup inst", 32'(alloc_ready), 32'd0);
        step();
        set_write(6, 8, 0); step();
        check_val("directed write_err unmatched", 32'(write_err), 32'd1);
        step();
        check_val("directed write_err one cycle", 32'(write_err), 32'd0);
        set_write(2, 17, 0); step();
        check_val("directed write_err out of range", 32'(write_err), 32'd1);
        check_mask("directed mask unchanged", rec_elementMask[2*MW +: MW], '0);

        // Write and retire on the same slot
        set_write(2, 8, 1); set_retire(2); step();
        check_val("directed write+retire idle", 32'(rec_valid[2]), 32'd0);
        check_mask("directed write+retire mask", rec_elementMask[2*MW +: MW], '0);

        // Reset with three live slots and a write in flight
        set_write(0, 8, 3); reset = 1'b1; step();
        check_val("directed reset clears", 32'(rec_valid), 32'd0);
        #2 check_val("directed ready after reset", 32'(alloc_ready), 32'd1);

        // Random traffic
        run_random(600);

        repeat (2) @(negedge clock);
        n_checks++;
        if (ready_q.size() != 0 || state_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d/%0d entries left, expected 0/0",
                     ready_q.size(), state_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chaining_record_writer.md
Name: chaining_record_writer

Overview:
Write side of the vector chaining scoreboard. It allocates one chaining record per issued instruction and sets that record's elementMask bits as writeback elements land. It frees the record when the instruction retires. Records are exported flat to the per-read chaining-check comparators, which treat a clear mask bit as "element not yet written" (a RAW hazard).

Parameters:
NUM_RECORDS, 4, number of record slots (2..8)
MASK_W, 512, elementMask width: 8 registers x 64 element offsets, relative to vd[2:0] of the record

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
alloc_valid  in  1  request new record
alloc_ready  out  1  slot free and instIndex not already live
alloc_vd_valid  in  1  instruction writes a vector register
alloc_vd  in  5  destination base register
alloc_instIndex  in  3  instruction index
alloc_elemCount  in  10  elements to be written, 1..512
write_valid  in  1  one element written this cycle
write_instIndex  in  3  owner of the write
write_vd  in  5  register written
write_offset  in  6  element offset inside register
retire_valid  in  1  instruction retired
retire_instIndex  in  3  instruction retiring
rec_valid  out  NUM_RECORDS  slot live
rec_vd_valid  out  NUM_RECORDS  per-slot vd_valid
rec_vd  out  5*NUM_RECORDS  per-slot vd
rec_instIndex  out  3*NUM_RECORDS  per-slot instIndex
rec_elementMask  out  MASK_W*NUM_RECORDS  per-slot mask, bit set = element written
rec_done  out  NUM_RECORDS  slot reached elemCount
write_err  out  1  registered pulse: write hit no live record or fell out of range

Behaviour:
- Reset: all slots IDLE; rec_valid, rec_vd_valid, rec_done and write_err are 0; masks, vd, instIndex and counters are 0. Reset asserted mid-operation discards every record at the next edge.
- Per-slot FSM has three states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on alloc fire to this slot.
  - ACTIVE -> DONE when the written-element count equals elemCount.
  - ACTIVE or DONE -> IDLE on retire of a matching instIndex.
- Alloc handshake:
  - Fire = alloc_valid & alloc_ready.
  - alloc_ready = (any IDLE slot) & (no live slot holds alloc_instIndex). It is combinational from current state only, with no dependency on alloc_valid.
  - The lowest-numbered IDLE slot is chosen.
  - The record is visible on rec_* the cycle after fire, with mask = 0 and count = 0.
- Write handling:
  - A write targets the live slot whose instIndex equals write_instIndex and whose vd_valid = 1.
  - rel = (write_vd - rec_vd) mod 32. If rel > 7, there is no update and write_err pulses.
  - Bit index = rel*64 + write_offset. The bit is set at the next edge.
  - The count increments only if the bit was previously 0, so duplicate writes are idempotent.
  - A write with no matching live record produces no update and a write_err pulse. A write to a DONE slot still sets the bit but does not increment the count.
- Retire: clears the matching slot at the next edge. A retire with no match is ignored.
- Simultaneous events:
  - Alloc and retire in the same cycle: alloc_ready and slot choice use pre-retire state, so a retiring slot cannot be reused until the following cycle.
  - Alloc and write to the same new instIndex in the same cycle: the write is treated as no-match and write_err pulses; upstream guarantees this never happens.
  - Write and retire on the same slot in the same cycle: retire wins and the slot ends IDLE.
  - Write that completes the count: rec_done rises one cycle after the completing write.
- Count width is 10 bits. elemCount = 512 is legal. The count never wraps because only 0->1 bit transitions increment it.

Decomposition:
- Shared package holds:
  - the chaining record struct {vd_valid, vd[4:0], instIndex[2:0], elementMask[511:0]}, which both this block and the check comparators use;
  - the slot-state enum;
  - the constants for registers per group (8) and elements per register (64).
- One sub-module, chaining_record_slot, holds one slot's FSM, mask, counter and match logic. The top module handles allocation priority, duplicate check and error OR.

Test Plan:
- Reset, then alloc vd=8, inst=2, count=3 -> alloc_ready=1; next cycle rec_valid[0]=1, mask=0, rec_done[0]=0.
- Write inst=2 at (vd=8, off=5), (vd=9, off=0), (vd=8, off=5) again, then (vd=10, off=63) -> mask bits 5, 64 and 191 set; count 3; rec_done[0]=1 one cycle after the fourth write; no write_err.
- Fill all 4 slots with inst 0..3 -> alloc_ready=0; retire inst=1 while alloc inst=5 is held -> alloc not accepted that cycle; accepted next cycle into slot 1.
- Alloc inst=3 while inst=3 is live -> alloc_ready=0. Write inst=6 (not live) -> write_err=1 for one cycle. Write inst=2 at vd=17 with record vd=8 -> write_err=1 and mask unchanged.
- Write and retire of inst=2 in the same cycle -> slot IDLE and mask 0 next cycle.
- Assert reset with 3 slots live and writes in flight -> all rec_valid=0 next cycle; alloc_ready=1.
